// File: rtl/present_decrypt_pkg.sv
// Shared constants, S-box tables and FSM encoding for the PRESENT-80 decryptor.
package present_pkg;

  localparam int ROUNDS  = 31;
  localparam int KEY_W   = 80;
  localparam int BLOCK_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_KEYEXP  = 2'd1,
    ST_DECRYPT = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Forward S-box; used only by the key schedule.
  localparam logic [3:0] SBOX [0:15] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] INV_SBOX [0:15] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

endpackage

// File: rtl/present_decrypt_if.sv
// Request/response bundle of the decryptor: start + key/ciphertext in,
// plaintext + status out.
interface present_decrypt_if;
  import present_pkg::*;

  logic               start_i;
  logic [KEY_W-1:0]   key_i;
  logic [BLOCK_W-1:0] data_i;
  logic [BLOCK_W-1:0] data_o;
  logic               busy_o;
  logic               valid_o;

  modport master (output start_i, key_i, data_i, input data_o, busy_o, valid_o);
  modport slave  (input start_i, key_i, data_i, output data_o, busy_o, valid_o);
endinterface

// File: rtl/present_decrypt_inv_sub_per.sv
// Inverse PRESENT round layer: undo the bit permutation, then the S-box layer.
module inv_sub_per
  import present_pkg::*;
(
  input  logic [BLOCK_W-1:0] din,
  output logic [BLOCK_W-1:0] dout
);

  logic [BLOCK_W-1:0] perm;

  // Bit j moves to (4*j) mod 63; bit 63 stays put.
  for (genvar j = 0; j < BLOCK_W - 1; j++) begin : g_perm
    assign perm[(4*j) % 63] = din[j];
  end
  assign perm[BLOCK_W-1] = din[BLOCK_W-1];

  for (genvar n = 0; n < BLOCK_W / 4; n++) begin : g_sbox
    assign dout[4*n +: 4] = INV_SBOX[perm[4*n +: 4]];
  end

endmodule

// File: rtl/present_decrypt.sv
// PRESENT-80 decryptor. The user key is first run forward to K32 (31 cycles),
// then the rounds are undone one per cycle while the key schedule is walked
// back down to K1 (31 cycles).
module present_decrypt
  import present_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  present_decrypt_if.slave  bus
);

  localparam logic [4:0] LAST_RND = 5'(ROUNDS);

  state_e             state_q, state_d;
  logic [4:0]         rnd_q, rnd_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [BLOCK_W-1:0] data_q, data_d;

  logic [KEY_W-1:0]   key_rot, key_fwd, key_x, key_inv;
  logic [BLOCK_W-1:0] isp_out;

  // Forward key update: rotate left 61, S-box top nibble, mix in round count.
  always_comb begin
    key_rot           = {key_q[18:0], key_q[79:19]};
    key_fwd           = key_rot;
    key_fwd[79:76]    = SBOX[key_rot[79:76]];
    key_fwd[19:15]    = key_rot[19:15] ^ rnd_q;
  end

  // Inverse key update: the forward steps undone in reverse order.
  always_comb begin
    key_x          = key_q;
    key_x[19:15]   = key_q[19:15] ^ rnd_q;
    key_x[79:76]   = INV_SBOX[key_q[79:76]];
    key_inv        = {key_x[60:0], key_x[79:61]};
  end

  inv_sub_per u_isp (
    .din  (data_q),
    .dout (isp_out)
  );

  // Next-state logic: capture, key expansion, decryption rounds, hold result.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    key_d   = key_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start_i) begin
          key_d   = bus.key_i;
          data_d  = bus.data_i;
          rnd_d   = 5'd1;
          state_d = ST_KEYEXP;
        end
      end
      ST_KEYEXP: begin
        key_d = key_fwd;
        if (rnd_q == LAST_RND) begin
          // key_fwd is K32 here: apply the final whitening key first.
          data_d  = data_q ^ key_fwd[79:16];
          state_d = ST_DECRYPT;
        end else begin
          rnd_d = rnd_q + 5'd1;
        end
      end
      ST_DECRYPT: begin
        key_d  = key_inv;
        data_d = isp_out ^ key_inv[79:16];
        rnd_d  = rnd_q - 5'd1;
        if (rnd_q == 5'd1) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rnd_q   <= '0;
      key_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      key_q   <= key_d;
      data_q  <= data_d;
    end
  end

  assign bus.busy_o  = (state_q == ST_KEYEXP) || (state_q == ST_DECRYPT);
  assign bus.valid_o = (state_q == ST_DONE);
  assign bus.data_o  = (state_q == ST_DONE) ? data_q : '0;

endmodule

// File: tb/tb_present_decrypt.sv
// Bench for present_decrypt: ciphertexts are produced by a PRESENT-80
// encryption model, and the DUT must recover the original plaintext.
module tb_present_decrypt;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  present_decrypt_if bus();

  present_decrypt dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  function automatic logic [3:0] sb(input logic [3:0] x);
    case (x)
      4'h0: sb = 4'hC; 4'h1: sb = 4'h5; 4'h2: sb = 4'h6; 4'h3: sb = 4'hB;
      4'h4: sb = 4'h9; 4'h5: sb = 4'h0; 4'h6: sb = 4'hA; 4'h7: sb = 4'hD;
      4'h8: sb = 4'h3; 4'h9: sb = 4'hE; 4'hA: sb = 4'hF; 4'hB: sb = 4'h8;
      4'hC: sb = 4'h4; 4'hD: sb = 4'h7; 4'hE: sb = 4'h1; default: sb = 4'h2;
    endcase
  endfunction

  function automatic logic [63:0] model_encrypt(input logic [63:0] pt, input logic [79:0] key);
    logic [79:0] k;
    logic [63:0] rk [1:32];
    logic [63:0] s, p;
    k = key;
    for (int i = 1; i <= 32; i++) begin
      rk[i] = k[79:16];
      k = {k[18:0], k[79:19]};
      k[79:76] = sb(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(i);
    end
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ rk[r];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sb(s[4*n +: 4]);
      p = '0;
      for (int b = 0; b < 64; b++) p[(b == 63) ? 63 : (16*b) % 63] = s[b];
      s = p;
    end
    return s ^ rk[32];
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Waits for valid_o; cyc = edges elapsed, or -1 if the bound expired.
  task automatic wait_valid(output int cyc);
    cyc = -1;
    for (int c = 1; c <= 120; c++) begin
      tick();
      if (bus.valid_o === 1'b1) begin
        cyc = c;
        break;
      end
    end
  endtask

  // Issue one start, check the accept cycle, latency and plaintext.
  task automatic run_op(input string name, input logic [79:0] key,
                        input logic [63:0] ct, input logic [63:0] exp);
    int cyc;
    bus.start_i = 1'b1; bus.key_i = key; bus.data_i = ct;
    tick();
    bus.start_i = 1'b0; bus.key_i = '1; bus.data_i = '1;
    vectors++;
    if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: valid=%b busy=%b, want valid=0 busy=1", name, bus.valid_o, bus.busy_o);
    end
    wait_valid(cyc);
    vectors++;
    if (cyc !== 62) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, want 62", name, cyc);
    end
    vectors++;
    if (bus.data_o !== exp || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s data: got %h busy=%b, want %h busy=0", name, bus.data_o, bus.busy_o, exp);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b1; bus.start_i = 1'b1; bus.key_i = '0; bus.data_i = '0;
    tick(); tick();
    vectors++;
    if (bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.data_o !== 64'h0) begin
      errors++;
      $display("FAIL reset: busy=%b valid=%b data=%h, want 0/0/0", bus.busy_o, bus.valid_o, bus.data_o);
    end
    bus.start_i = 1'b0;
    rst_i = 1'b0;
    tick();
    vectors++;
    if (bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL idle: busy=%b valid=%b, want 0/0", bus.busy_o, bus.valid_o);
    end
  endtask

  task automatic test_known();
    run_op("kat_zero",  80'h0, 64'h5579C1387B228445, 64'h0);
    run_op("kat_ones",  {80{1'b1}}, 64'hE72C46C0F5945049, 64'h0);
    run_op("kat_zk_1p", 80'h0, 64'hA112FFC72F68417B, 64'hFFFFFFFFFFFFFFFF);
    // Still in DONE here: the next start is a restart from DONE.
    run_op("restart_done", {80{1'b1}}, 64'h3333DCD3213210D2, 64'hFFFFFFFFFFFFFFFF);
  endtask

  task automatic test_random();
    logic [79:0] k;
    logic [63:0] pt;
    for (int i = 0; i < 6; i++) begin
      k  = {16'($urandom), $urandom, $urandom};
      pt = {$urandom, $urandom};
      run_op("random", k, model_encrypt(pt, k), pt);
    end
  endtask

  task automatic test_ignore_start();
    logic [79:0] k;
    logic [63:0] pt;
    int cyc;
    k  = {16'($urandom), $urandom, $urandom};
    pt = {$urandom, $urandom};
    bus.start_i = 1'b1; bus.key_i = k; bus.data_i = model_encrypt(pt, k);
    tick();
    cyc = -1;
    for (int c = 1; c <= 120; c++) begin
      bus.start_i = (c == 10);
      bus.key_i   = ~k;
      bus.data_i  = ~pt;
      tick();
      if (bus.valid_o === 1'b1) begin cyc = c; break; end
    end
    bus.start_i = 1'b0;
    vectors++;
    if (cyc !== 62 || bus.data_o !== pt) begin
      errors++;
      $display("FAIL ignore_start: cyc=%0d data=%h, want cyc=62 data=%h", cyc, bus.data_o, pt);
    end
  endtask

  task automatic test_reset_mid();
    logic [79:0] k;
    logic [63:0] pt;
    k  = {16'($urandom), $urandom, $urandom};
    pt = {$urandom, $urandom};
    bus.start_i = 1'b1; bus.key_i = k; bus.data_i = model_encrypt(pt, k);
    tick();
    bus.start_i = 1'b0;
    for (int c = 1; c < 40; c++) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    vectors++;
    if (bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.data_o !== 64'h0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b valid=%b data=%h, want 0/0/0", bus.busy_o, bus.valid_o, bus.data_o);
    end
    tick();
    vectors++;
    if (bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: busy=%b, want 0", bus.busy_o);
    end
    run_op("after_reset", k, model_encrypt(pt, k), pt);
  endtask

  task automatic test_back_to_back();
    logic [79:0] k;
    logic [63:0] pt;
    int hits [$];
    k  = {16'($urandom), $urandom, $urandom};
    pt = {$urandom, $urandom};
    bus.start_i = 1'b1; bus.key_i = k; bus.data_i = model_encrypt(pt, k);
    tick();
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (bus.valid_o === 1'b1) begin
        hits.push_back(c);
        vectors++;
        if (bus.data_o !== pt) begin
          errors++;
          $display("FAIL b2b_data: got %h, want %h", bus.data_o, pt);
        end
      end
    end
    bus.start_i = 1'b0;
    vectors++;
    if (hits.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d valid cycles, want 3", hits.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (hits[i] != 62 + 63 * i) begin
          errors++;
          $display("FAIL b2b_timing: pulse %0d at %0d, want %0d", i, hits[i], 62 + 63 * i);
        end
      end
    end
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.key_i   = '0;
    bus.data_i  = '0;
    test_reset();
    test_known();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/present_decrypt.md
PRESENT_DECRYPT -- requirements
Module: present_decrypt

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 start_i  input  1  request; sampled only in IDLE or DONE.
REQ-005 key_i  input  80  PRESENT-80 user key; captured with start_i.
REQ-006 data_i  input  64  ciphertext; captured with start_i.
REQ-007 data_o  output  64  plaintext; valid while valid_o=1.
REQ-008 busy_o  output  1  high in KEYEXP and DECRYPT.
REQ-009 valid_o  output  1  high in DONE.

Function
REQ-010 FSM states SHALL be IDLE, KEYEXP, DECRYPT, DONE; reset state IDLE.
REQ-011 IDLE/DONE with start_i=1 at edge N: load key_reg=key_i, data_reg=data_i, rnd=1 (5 bits), go to KEYEXP; valid_o drops.
REQ-012 start_i in KEYEXP/DECRYPT SHALL be ignored; key_i/data_i changes after capture SHALL have no effect.
REQ-013 KEYEXP, per cycle: forward key update: rotate left 61, S-box on [79:76], XOR rnd into [19:15]; rnd++.
REQ-014 KEYEXP cycle with rnd=31: after the update, data_reg <= data_reg XOR updated_key[79:16] (K32 whitening); go to DECRYPT with rnd=31.
REQ-015 DECRYPT, per cycle: k' = inverse key update of key_reg (XOR rnd into [19:15], inverse S-box on [79:76], rotate right 61); key_reg<=k'; data_reg <= inv_sub_per(data_reg) XOR k'[79:16]; rnd--.
REQ-016 DECRYPT cycle with rnd=1 SHALL be the last; next state DONE.
REQ-017 Latency: start accepted at edge N -> valid_o=1 and correct data_o after edge N+62 (31 KEYEXP + 31 DECRYPT cycles).
REQ-018 DONE SHALL hold data_o and valid_o=1 until reset or a new start.
REQ-019 data_o SHALL equal data_reg in DONE, 64'h0 otherwise.
REQ-020 Inverse permutation: input bit j -> output bit (4*j) mod 63 for j<63; bit 63 -> 63.
REQ-021 Inverse S-box (nibble 0..F): 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A; applied to all 16 nibbles after inverse permutation.
REQ-022 Round counter SHALL never wrap: range 1..31 in KEYEXP/DECRYPT.

Reset
REQ-023 rst_i=1 at any edge, including mid-KEYEXP/DECRYPT, SHALL force IDLE, rnd=0, key_reg=0, data_reg=0, busy_o=0, valid_o=0, data_o=0.
REQ-024 rst_i SHALL take priority over start_i in the same cycle.

Structure
REQ-025 Package present_pkg SHALL hold SBOX and INV_SBOX tables, FSM state enum, ROUNDS=31, KEY_W=80, BLOCK_W=64.
REQ-026 One combinational sub-module inv_sub_per (inverse permutation then inverse substitution, 64-bit in/out) SHALL be instantiated; key updates stay in the top module.

Verification
REQ-027 key_i=0, data_i=64'h5579C1387B228445, start 1 cycle -> valid_o after 62 cycles, data_o=64'h0.
REQ-028 key_i=80'hFFFF_FFFFFFFF_FFFFFFFF, data_i=64'hE72C46C0F5945049 -> data_o=64'h0.
REQ-029 key_i=0, data_i=64'hA112FFC72F68417B -> data_o=64'hFFFFFFFFFFFFFFFF; then key all-ones, data_i=64'h3333DCD3213210D2, start issued in DONE -> valid_o drops next cycle, data_o=64'hFFFFFFFFFFFFFFFF 62 cycles later.
REQ-030 start_i pulsed at cycle 10 of an operation with different key/data -> ignored; first result unchanged, completes at cycle 62.
REQ-031 rst_i asserted at cycle 40 of an operation -> next cycle IDLE, all outputs 0; new start gives correct result 62 cycles later.
REQ-032 start_i held high continuously -> back-to-back operations, each valid_o for exactly one cycle, every 63 cycles.
